// File: rtl/intmul_arbiter.sv
// intmul_arbiter: round-robin arbiter sharing one external pipelined 60x60 multiplier
// between NREQ requesters, with an in-order result FIFO.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-low reset
//   req_valid  per-requester operand-pair valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_a/b    packed 60-bit operands, requester i at [60i+59:60i]
//   mul_a/b    registered operands driven to the multiplier
//   mul_d      multiplier product, valid MUL_LAT cycles after mul_a/mul_b load
//   rsp_valid  result FIFO head valid
//   rsp_ready  consumer accept
//   rsp_id     requester index of the head result
//   rsp_data   head product (120-bit unsigned)
//   busy       high while any issued result has not yet been popped
module intmul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [60*NREQ-1:0]       req_a,
  input  logic [60*NREQ-1:0]       req_b,
  output logic [59:0]              mul_a,
  output logic [59:0]              mul_b,
  input  logic [119:0]             mul_d,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [119:0]             rsp_data,
  output logic                     busy
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Round-robin pointer and outstanding count
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Operand registers feeding the multiplier
  logic [59:0] mul_a_q, mul_a_d;
  logic [59:0] mul_b_q, mul_b_d;

  // Tag pipe tracks which requester owns the product emerging from the multiplier
  logic [MUL_LAT:0]          tag_vld_q;
  logic [MUL_LAT:0][IdW-1:0] tag_id_q;

  // Result FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic [119:0]    fifo_data_q [DEPTH];
  logic [IdW-1:0]  fifo_id_q   [DEPTH];

  logic [59:0]     a_arr [NREQ];
  logic [59:0]     b_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IdW-1:0]  gnt_idx;
  logic [IdW-1:0]  idx;
  logic            gnt_found;
  logic            accept_ok;
  logic            accept;
  logic            push;
  logic            pop;
  logic            fifo_empty;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[60*g +: 60];
    assign b_arr[g] = req_b[60*g +: 60];
  end

  // First valid requester at or above the pointer, wrapping modulo NREQ
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IdW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = idx;
        gnt_found  = 1'b1;
      end
    end
  end

  // No pop bypass: a full outstanding count blocks accepts even on a pop cycle
  assign accept_ok = rst && (cnt_q < CntW'(DEPTH));
  assign req_ready = accept_ok ? grant : '0;
  assign accept    = accept_ok && gnt_found;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign rsp_valid  = rst && !fifo_empty;
  assign rsp_data   = fifo_data_q[rd_ptr_q[PtrW-1:0]];
  assign rsp_id     = fifo_id_q[rd_ptr_q[PtrW-1:0]];
  assign push       = tag_vld_q[MUL_LAT];
  assign pop        = rsp_valid && rsp_ready;
  assign busy       = (cnt_q != '0);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;

  always_comb begin
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (accept) begin
      ptr_d   = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + IdW'(1);
      mul_a_d = a_arr[gnt_idx];
      mul_b_d = b_arr[gnt_idx];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      for (int unsigned s = MUL_LAT; s > 0; s--) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      tag_vld_q[0] <= accept;
      tag_id_q[0]  <= gnt_idx;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
      end
    end
  end

  // Storage needs no reset; pointers alone define occupancy
  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_data_q[wr_ptr_q[PtrW-1:0]] <= mul_d;
      fifo_id_q[wr_ptr_q[PtrW-1:0]]   <= tag_id_q[MUL_LAT];
    end
  end

endmodule

// File: tb/tb_intmul_arbiter.sv
// Self-checking bench for intmul_arbiter with a behavioural pipelined multiplier.
module tb_intmul_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned MUL_LAT = 1;
  localparam int unsigned DEPTH   = 4;

  logic           clk;
  logic           rst;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [239:0]   req_a;
  logic [239:0]   req_b;
  logic [59:0]    mul_a;
  logic [59:0]    mul_b;
  logic [119:0]   mul_d;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [119:0]   rsp_data;
  logic           busy;

  int tests;
  int fails;

  intmul_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_d     (mul_d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: MUL_LAT register stages from operands to product
  logic [119:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= {60'd0, mul_a} * {60'd0, mul_b};
    for (int i = 1; i < int'(MUL_LAT); i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_d = mpipe[MUL_LAT-1];

  typedef struct {
    logic [1:0]   id;
    logic [59:0]  a;
    logic [59:0]  b;
    logic [119:0] p;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset one edge with all requesters asking; nothing may be granted
  task automatic do_reset();
    rst       = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    #1;
    chk("rst_ready", 120'(req_ready), 120'(0));
    chk("rst_rsp_valid", 120'(rsp_valid), 120'(0));
    tick();
    req_valid = 4'h0;
    rst       = 1'b1;
    chk("rst_busy", 120'(busy), 120'(0));
    chk("rst_mul_a", 120'(mul_a), 120'(0));
    chk("rst_rsp_valid_after", 120'(rsp_valid), 120'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_got;
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{id: 2'd0, a: 60'd3, b: 60'd5, p: 120'd15};
    vecs[1] = '{id: 2'd2, a: 60'hFFF_FFFF_FFFF_FFFF, b: 60'hFFF_FFFF_FFFF_FFFF,
                p: 120'hFFFFFFFFFFFFFFE000000000000001};
    vecs[2] = '{id: 2'd1, a: 60'd12345, b: 60'd6789, p: 120'd83810205};
    vecs[3] = '{id: 2'd3, a: 60'h800_0000_0000_0000, b: 60'd4, p: 120'h2000000000000000};
    vecs[4] = '{id: 2'd1, a: 60'h800_0000_0000_0000, b: 60'h800_0000_0000_0000,
                p: 120'h400000000000000000000000000000};
    vecs[5] = '{id: 2'd2, a: 60'h123_4567_89AB_CDEF, b: 60'd16, p: 120'h123456789ABCDEF0};

    do_reset();

    // Single transactions: grant, operand load, exact latency, hold, pop
    for (int v = 0; v < 6; v++) begin
      req_a     = 240'(vecs[v].a) << (60 * int'(vecs[v].id));
      req_b     = 240'(vecs[v].b) << (60 * int'(vecs[v].id));
      req_valid = 4'b0001 << vecs[v].id;
      #1;
      chk("single_grant", 120'(req_ready), 120'(4'b0001 << vecs[v].id));
      tick();
      req_valid = 4'h0;
      chk("single_mul_a", 120'(mul_a), 120'(vecs[v].a));
      chk("single_mul_b", 120'(mul_b), 120'(vecs[v].b));
      for (int i = 0; i <= int'(MUL_LAT); i++) begin
        chk("single_early", 120'(rsp_valid), 120'(0));
        tick();
      end
      chk("single_valid", 120'(rsp_valid), 120'(1));
      chk("single_id", 120'(rsp_id), 120'(vecs[v].id));
      chk("single_data", rsp_data, vecs[v].p);
      chk("single_busy", 120'(busy), 120'(1));
      tick();
      chk("single_hold_data", rsp_data, vecs[v].p);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("single_popped", 120'(rsp_valid), 120'(0));
      chk("single_idle", 120'(busy), 120'(0));
    end

    // Fairness: all request, results drain continuously
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[60*i +: 60] = 60'(i + 1);
      req_b[60*i +: 60] = 60'd10;
    end
    rsp_ready = 1'b1;
    n_got     = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      req_valid = (cyc < 5) ? 4'hF : 4'h0;
      #1;
      if (cyc < 5) chk("rr_grant", 120'(req_ready), 120'(4'b0001 << (cyc % 4)));
      if (rsp_valid) begin
        if (n_got < 5) begin
          chk("rr_id", 120'(rsp_id), 120'(n_got % 4));
          chk("rr_data", rsp_data, 120'(((n_got % 4) + 1) * 10));
        end else begin
          chk("rr_extra_rsp", 120'(rsp_valid), 120'(0));
        end
        n_got++;
      end
      tick();
    end
    chk("rr_count", 120'(n_got), 120'(5));
    chk("rr_idle", 120'(busy), 120'(0));

    // Backpressure: exactly DEPTH accepts, then one pop frees exactly one slot
    do_reset();
    req_a     = 240'(60'd7);
    req_b     = 240'(60'd9);
    req_valid = 4'b0001;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      chk("bp_ready", 120'(req_ready), 120'((cyc < int'(DEPTH)) ? 1 : 0));
      tick();
    end
    chk("bp_head_valid", 120'(rsp_valid), 120'(1));
    chk("bp_head_data", rsp_data, 120'd63);
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_bypass", 120'(req_ready), 120'(0));
    tick();
    rsp_ready = 1'b0;
    chk("bp_one_more", 120'(req_ready), 120'(1));
    tick();
    chk("bp_full_again", 120'(req_ready), 120'(0));
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    n_got     = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (rsp_valid) begin
        chk("bp_drain_id", 120'(rsp_id), 120'(0));
        chk("bp_drain_data", rsp_data, 120'd63);
        n_got++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    chk("bp_drain_count", 120'(n_got), 120'(DEPTH));
    chk("bp_idle", 120'(busy), 120'(0));

    // Mid-operation reset: two accepts, reset before any result lands
    do_reset();
    req_a     = {4{60'd3}};
    req_b     = {4{60'd5}};
    req_valid = 4'b0011;
    #1;
    chk("mid_grant0", 120'(req_ready), 120'(4'b0001));
    tick();
    chk("mid_grant1", 120'(req_ready), 120'(4'b0010));
    tick();
    req_valid = 4'h0;
    rst       = 1'b0;
    #1;
    chk("mid_rst_valid", 120'(rsp_valid), 120'(0));
    tick();
    rst = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      chk("mid_no_rsp", 120'(rsp_valid), 120'(0));
      chk("mid_not_busy", 120'(busy), 120'(0));
      tick();
    end
    chk("mid_mul_a", 120'(mul_a), 120'(0));
    req_valid = 4'hF;
    #1;
    chk("mid_ptr_zero", 120'(req_ready), 120'(4'b0001));
    req_valid = 4'h0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
